// File: rtl/default_table_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : default_table_arbiter
//  Purpose  : Two-port Avalon-MM arbiter sharing a single-port default-value
//             RAM between requester A (HPS lightweight bridge) and
//             requester B (fabric configuration loader). Accesses are
//             serialised with round-robin priority. The RAM's clock enable
//             is gated while a RAM reset request is pending.
//  Ports    :
//    clk, reset             clock, synchronous active-high reset
//    reset_req              RAM reset request (blocks grants, gates ram_clken)
//    a_* / b_*              Avalon-MM pipelined slave per requester
//                           (fixed read latency of 2 cycles after accept)
//    ram_*                  registered command to the RAM s1 slave,
//                           ram_readdata returned one cycle after address
//    ram_clken              RAM clock enable (~reset_req)
//  Revision : 1.0  initial release
// ============================================================================
module default_table_arbiter #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reset_req,
  // requester A
  input  logic [ADDR_W-1:0] a_address,
  input  logic [BE_W-1:0]   a_byteenable,
  input  logic              a_read,
  input  logic              a_write,
  input  logic [DATA_W-1:0] a_writedata,
  output logic              a_waitrequest,
  output logic [DATA_W-1:0] a_readdata,
  output logic              a_readdatavalid,
  // requester B
  input  logic [ADDR_W-1:0] b_address,
  input  logic [BE_W-1:0]   b_byteenable,
  input  logic              b_read,
  input  logic              b_write,
  input  logic [DATA_W-1:0] b_writedata,
  output logic              b_waitrequest,
  output logic [DATA_W-1:0] b_readdata,
  output logic              b_readdatavalid,
  // RAM s1 slave
  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  input  logic [DATA_W-1:0] ram_readdata,
  output logic              ram_clken
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    READ_WAIT = 2'd2,
    RESP      = 2'd3
  } state_t;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  state_t            r_state;
  logic              r_owner;
  logic              r_last_grant;
  logic              r_a_rdv;
  logic              r_b_rdv;
  logic [DATA_W-1:0] r_a_rdata;
  logic [DATA_W-1:0] r_b_rdata;
  logic [ADDR_W-1:0] r_ram_address;
  logic [BE_W-1:0]   r_ram_byteenable;
  logic              r_ram_chipselect;
  logic              r_ram_write;
  logic [DATA_W-1:0] r_ram_writedata;

  logic              w_a_req;
  logic              w_b_req;
  logic              w_grant_b;
  logic              w_accept;
  logic              w_sel_write;
  logic [ADDR_W-1:0] w_sel_address;
  logic [BE_W-1:0]   w_sel_byteenable;
  logic [DATA_W-1:0] w_sel_writedata;

  assign w_a_req = a_read | a_write;
  assign w_b_req = b_read | b_write;

  // B wins when it is alone, or on a tie when A was granted last.
  assign w_grant_b = w_b_req & (~w_a_req | (r_last_grant == OWNER_A));

  // Write has precedence over read when both strobes are raised together.
  assign w_sel_write      = w_grant_b ? b_write      : a_write;
  assign w_sel_address    = w_grant_b ? b_address    : a_address;
  assign w_sel_byteenable = w_grant_b ? b_byteenable : a_byteenable;
  assign w_sel_writedata  = w_grant_b ? b_writedata  : a_writedata;

  // The RAM only samples the command when its clock is enabled, so the
  // accept cycle is the first ISSUE cycle with reset_req low.
  assign w_accept = (r_state == ISSUE) & ~reset_req;

  assign a_waitrequest   = ~(w_accept & (r_owner == OWNER_A));
  assign b_waitrequest   = ~(w_accept & (r_owner == OWNER_B));
  assign a_readdata      = r_a_rdata;
  assign b_readdata      = r_b_rdata;
  assign a_readdatavalid = r_a_rdv;
  assign b_readdatavalid = r_b_rdv;

  assign ram_address    = r_ram_address;
  assign ram_byteenable = r_ram_byteenable;
  assign ram_chipselect = r_ram_chipselect;
  assign ram_write      = r_ram_write;
  assign ram_writedata  = r_ram_writedata;
  assign ram_clken      = ~reset_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= IDLE;
      r_owner          <= OWNER_A;
      r_last_grant     <= OWNER_B;
      r_a_rdv          <= 1'b0;
      r_b_rdv          <= 1'b0;
      r_a_rdata        <= '0;
      r_b_rdata        <= '0;
      r_ram_address    <= '0;
      r_ram_byteenable <= '0;
      r_ram_chipselect <= 1'b0;
      r_ram_write      <= 1'b0;
      r_ram_writedata  <= '0;
    end else begin
      r_a_rdv <= 1'b0;
      r_b_rdv <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!reset_req && (w_a_req || w_b_req)) begin
            r_owner          <= w_grant_b;
            r_ram_address    <= w_sel_address;
            r_ram_byteenable <= w_sel_write ? w_sel_byteenable : '1;
            r_ram_chipselect <= 1'b1;
            r_ram_write      <= w_sel_write;
            r_ram_writedata  <= w_sel_writedata;
            r_state          <= ISSUE;
          end else begin
            r_ram_chipselect <= 1'b0;
            r_ram_write      <= 1'b0;
          end
        end
        ISSUE: begin
          // While reset_req is high the command is simply held.
          if (!reset_req) begin
            r_last_grant     <= r_owner;
            r_ram_chipselect <= 1'b0;
            r_ram_write      <= 1'b0;
            r_state          <= r_ram_write ? IDLE : READ_WAIT;
          end
        end
        READ_WAIT: begin
          // Address is already latched in the RAM and q holds, so
          // reset_req has no effect here.
          if (r_owner == OWNER_B) begin
            r_b_rdata <= ram_readdata;
            r_b_rdv   <= 1'b1;
          end else begin
            r_a_rdata <= ram_readdata;
            r_a_rdv   <= 1'b1;
          end
          r_state <= RESP;
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_default_table_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_default_table_arbiter
//  Purpose  : Self-checking bench for default_table_arbiter. Directed Avalon
//             masters drive both ports; a RAM model closes the loop; read
//             responses are checked by a scoreboard monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_default_table_arbiter;

  localparam int ADDR_W = 2;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              reset_req;
  logic [ADDR_W-1:0] a_address, b_address;
  logic [BE_W-1:0]   a_byteenable, b_byteenable;
  logic              a_read, b_read, a_write, b_write;
  logic [DATA_W-1:0] a_writedata, b_writedata;
  logic              a_waitrequest, b_waitrequest;
  logic [DATA_W-1:0] a_readdata, b_readdata;
  logic              a_readdatavalid, b_readdatavalid;
  logic [ADDR_W-1:0] ram_address;
  logic [BE_W-1:0]   ram_byteenable;
  logic              ram_chipselect, ram_write, ram_clken;
  logic [DATA_W-1:0] ram_writedata;
  logic [DATA_W-1:0] ram_q;

  default_table_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) dut (
    .clk(clk), .reset(reset), .reset_req(reset_req),
    .a_address(a_address), .a_byteenable(a_byteenable), .a_read(a_read),
    .a_write(a_write), .a_writedata(a_writedata), .a_waitrequest(a_waitrequest),
    .a_readdata(a_readdata), .a_readdatavalid(a_readdatavalid),
    .b_address(b_address), .b_byteenable(b_byteenable), .b_read(b_read),
    .b_write(b_write), .b_writedata(b_writedata), .b_waitrequest(b_waitrequest),
    .b_readdata(b_readdata), .b_readdatavalid(b_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_readdata(ram_q), .ram_clken(ram_clken)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Single-port RAM model: registered q, byte-lane writes, clock enable.
  logic [31:0] mem [4];
  int ram_wr_count = 0;
  int clken_low_count = 0;
  always @(posedge clk) begin
    if (!ram_clken) clken_low_count <= clken_low_count + 1;
    if (ram_clken && ram_chipselect) begin
      if (ram_write) begin
        ram_wr_count <= ram_wr_count + 1;
        for (int i = 0; i < 4; i++)
          if (ram_byteenable[i]) mem[ram_address][8*i +: 8] <= ram_writedata[8*i +: 8];
      end else begin
        ram_q <= mem[ram_address];
      end
    end
  end

  typedef struct {
    bit          port;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int s, acc, acc2, w0, c0;
  bit prev_a_pend, prev_b_pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_rdv(input bit port, input logic [31:0] data);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_rdv port %0d: got data %h, required no response (cycle %0d)",
               port, data, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("resp_port", {31'd0, port}, {31'd0, e.port});
      chk("resp_data", data, e.data);
      chk("resp_cycle", cyc, e.cyc);
    end
  endtask

  // Drive one Avalon command on a port and hold it until accepted.
  task automatic master(input bit port, input bit rd, input bit wr,
                        input logic [1:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, input bit expect_resp,
                        input logic [31:0] exp_data, output int acc_cyc);
    exp_t e;
    if (port) begin
      b_read = rd; b_write = wr; b_address = addr; b_byteenable = be; b_writedata = wd;
    end else begin
      a_read = rd; a_write = wr; a_address = addr; a_byteenable = be; a_writedata = wd;
    end
    acc_cyc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!(port ? b_waitrequest : a_waitrequest)) begin
        acc_cyc = cyc;
        break;
      end
    end
    if (acc_cyc >= 0 && expect_resp) begin
      e.port = port; e.data = exp_data; e.cyc = acc_cyc + 2;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    if (port) begin b_read = 1'b0; b_write = 1'b0; end
    else      begin a_read = 1'b0; a_write = 1'b0; end
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_a_wait"}, {31'd0, a_waitrequest}, 32'd1);
    chk({tag, "_b_wait"}, {31'd0, b_waitrequest}, 32'd1);
    chk({tag, "_a_rdv"}, {31'd0, a_readdatavalid}, 32'd0);
    chk({tag, "_b_rdv"}, {31'd0, b_readdatavalid}, 32'd0);
    chk({tag, "_a_rdata"}, a_readdata, 32'd0);
    chk({tag, "_b_rdata"}, b_readdata, 32'd0);
    chk({tag, "_ram_addr"}, {30'd0, ram_address}, 32'd0);
    chk({tag, "_ram_be"}, {28'd0, ram_byteenable}, 32'd0);
    chk({tag, "_ram_cs"}, {31'd0, ram_chipselect}, 32'd0);
    chk({tag, "_ram_wr"}, {31'd0, ram_write}, 32'd0);
    chk({tag, "_ram_wd"}, ram_writedata, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; reset_req = 1'b0;
    a_address = '0; a_byteenable = '0; a_read = 1'b0; a_write = 1'b0; a_writedata = '0;
    b_address = '0; b_byteenable = '0; b_read = 1'b0; b_write = 1'b0; b_writedata = '0;
    prev_a_pend = 1'b0; prev_b_pend = 1'b0;

    // Monitor: scoreboard on readdatavalid, Avalon hold-rule checks, read byteenables.
    fork
      forever begin
        @(negedge clk);
        if (!reset) begin
          if (a_readdatavalid) check_rdv(1'b0, a_readdata);
          if (b_readdatavalid) check_rdv(1'b1, b_readdata);
          if (prev_a_pend && !(a_read || a_write)) begin
            errors++;
            $display("FAIL avalon_hold_a: request dropped while waitrequest high (cycle %0d)", cyc);
          end
          if (prev_b_pend && !(b_read || b_write)) begin
            errors++;
            $display("FAIL avalon_hold_b: request dropped while waitrequest high (cycle %0d)", cyc);
          end
          if (ram_chipselect && !ram_write && ram_clken)
            chk("read_byteenable", {28'd0, ram_byteenable}, 32'h0000000F);
          prev_a_pend = (a_read || a_write) && a_waitrequest;
          prev_b_pend = (b_read || b_write) && b_waitrequest;
        end else begin
          prev_a_pend = 1'b0;
          prev_b_pend = 1'b0;
        end
      end
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    chk("rst_ram_clken", {31'd0, ram_clken}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;

    // A write addr 2 = DEADBEEF; command visible on the RAM in the accept cycle.
    s = cyc; w0 = ram_wr_count;
    fork
      master(1'b0, 1'b0, 1'b1, 2'd2, 4'hF, 32'hDEADBEEF, 1'b0, 32'd0, acc);
      begin
        @(negedge clk);
        @(negedge clk);
        chk("wr1_ram_write", {31'd0, ram_write}, 32'd1);
        chk("wr1_ram_cs", {31'd0, ram_chipselect}, 32'd1);
        chk("wr1_ram_addr", {30'd0, ram_address}, 32'd2);
        chk("wr1_ram_wd", ram_writedata, 32'hDEADBEEF);
      end
    join
    chk("wr1_accept_cycle", acc, s + 1);
    settle();
    chk("wr1_ram_wr_count", ram_wr_count - w0, 32'd1);

    // A read addr 2 -> DEADBEEF two cycles after accept.
    s = cyc;
    master(1'b0, 1'b1, 1'b0, 2'd2, 4'h0, 32'd0, 1'b1, 32'hDEADBEEF, acc);
    chk("rd1_accept_cycle", acc, s + 1);
    settle();

    // Preload addr 0 (by A) and addr 1 (by B).
    master(1'b0, 1'b0, 1'b1, 2'd0, 4'hF, 32'h01010101, 1'b0, 32'd0, acc);
    settle();
    master(1'b1, 1'b0, 1'b1, 2'd1, 4'hF, 32'h02020202, 1'b0, 32'd0, acc);
    settle();

    // Simultaneous reads after a B grant: A goes first.
    s = cyc;
    fork
      master(1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 32'd0, 1'b1, 32'h01010101, acc);
      master(1'b1, 1'b1, 1'b0, 2'd1, 4'h0, 32'd0, 1'b1, 32'h02020202, acc2);
    join
    chk("pair1_a_accept", acc, s + 1);
    chk("pair1_b_accept", acc2, s + 5);
    settle();

    // B byte-lane write over DEADBEEF, then A reads back the merge.
    master(1'b1, 1'b0, 1'b1, 2'd2, 4'h3, 32'h11223344, 1'b0, 32'd0, acc);
    settle();
    s = cyc;
    master(1'b0, 1'b1, 1'b0, 2'd2, 4'h0, 32'd0, 1'b1, 32'hDEAD3344, acc);
    chk("rd_merge_accept", acc, s + 1);
    settle();

    // Simultaneous reads after an A grant: B goes first.
    s = cyc;
    fork
      master(1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 32'd0, 1'b1, 32'h01010101, acc);
      master(1'b1, 1'b1, 1'b0, 2'd1, 4'h0, 32'd0, 1'b1, 32'h02020202, acc2);
    join
    chk("pair2_b_accept", acc2, s + 1);
    chk("pair2_a_accept", acc, s + 5);
    settle();

    // reset_req high for 3 cycles while in ISSUE.
    s = cyc; c0 = clken_low_count;
    fork
      master(1'b0, 1'b1, 1'b0, 2'd1, 4'h0, 32'd0, 1'b1, 32'h02020202, acc);
      begin
        @(posedge clk); #1;
        reset_req = 1'b1;
        @(negedge clk);
        chk("stall_clken", {31'd0, ram_clken}, 32'd0);
        chk("stall_a_wait", {31'd0, a_waitrequest}, 32'd1);
        chk("stall_ram_cs", {31'd0, ram_chipselect}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        reset_req = 1'b0;
      end
    join
    chk("stall_accept_cycle", acc, s + 4);
    settle();
    chk("stall_clken_low_cycles", clken_low_count - c0, 32'd3);

    // reset during READ_WAIT drops the read.
    s = cyc;
    master(1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 32'd0, 1'b0, 32'd0, acc);
    chk("midrst_accept_cycle", acc, s + 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");
    @(posedge clk); #1;
    s = cyc;
    master(1'b0, 1'b1, 1'b0, 2'd2, 4'h0, 32'd0, 1'b1, 32'hDEAD3344, acc);
    chk("postrst_accept_cycle", acc, s + 1);
    settle();

    // Read and write together: treated as write, no response.
    s = cyc; w0 = ram_wr_count;
    master(1'b0, 1'b1, 1'b1, 2'd3, 4'hF, 32'hCAFEF00D, 1'b0, 32'd0, acc);
    chk("rw_accept_cycle", acc, s + 1);
    settle();
    chk("rw_ram_wr_count", ram_wr_count - w0, 32'd1);
    chk("rw_mem3", mem[3], 32'hCAFEF00D);
    master(1'b0, 1'b1, 1'b0, 2'd3, 4'h0, 32'd0, 1'b1, 32'hCAFEF00D, acc);
    settle();

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/default_table_arbiter.md
# default_table_arbiter

Two-port Avalon-MM arbiter that shares the single-port 4-word x 32-bit on-chip default-value RAM between the HPS lightweight bridge (requester A) and the fabric configuration loader (requester B). It sits between the two masters and the RAM's s1 slave, serialises their accesses with round-robin priority, and respects the RAM's clock-enable gating during reset requests. Each requester sees an Avalon-MM pipelined slave with fixed read latency.

## Interface

Parameters:
- ADDR_W, 2, word address width of the RAM (depth 2^ADDR_W)
- DATA_W, 32, data width
- BE_W, 4, byteenable width (DATA_W/8)

Ports:
- clk  in  1  single clock for all logic
- reset  in  1  synchronous, active-high reset
- reset_req  in  1  RAM reset request; high blocks new grants and gates ram_clken
- a_address / b_address  in  ADDR_W  word address from requester A / B
- a_byteenable / b_byteenable  in  BE_W  write byte lanes
- a_read / b_read  in  1  read request
- a_write / b_write  in  1  write request
- a_writedata / b_writedata  in  DATA_W  write data
- a_waitrequest / b_waitrequest  out  1  low only in the command-accept cycle
- a_readdata / b_readdata  out  DATA_W  registered read data
- a_readdatavalid / b_readdatavalid  out  1  one-cycle pulse qualifying readdata
- ram_address  out  ADDR_W  registered RAM address
- ram_byteenable  out  BE_W  registered byte lanes (all ones for reads)
- ram_chipselect  out  1  registered chip select
- ram_write  out  1  registered write strobe
- ram_writedata  out  DATA_W  registered write data
- ram_readdata  in  DATA_W  RAM q, valid the cycle after the address is clocked in
- ram_clken  out  1  RAM clock enable = ~reset_req (combinational)

## Operation

- FSM states: IDLE, ISSUE, READ_WAIT, RESP.
- IDLE: if reset_req low and any requester has read|write high, select winner, register its command into ram_* and the owner flag, go ISSUE. Otherwise ram_chipselect=0, ram_write=0.
- Arbitration: round-robin on a last_grant bit; on tie, grant the requester not granted last. last_grant resets to B, so A wins the first tie. A single requester is granted immediately.
- Read and write both high from one requester: treated as a write; read ignored.
- ISSUE: ram_chipselect=1 (ram_write=1 for writes). If reset_req high, stay in ISSUE with command held and owner waitrequest high. Else owner waitrequest=0 for this cycle (accept), update last_grant, go READ_WAIT (read) or IDLE (write).
- READ_WAIT: ram_chipselect=0; capture ram_readdata into owner's readdata register; go RESP. reset_req is ignored here (address already latched; q holds).
- RESP: owner readdatavalid=1 for exactly this cycle; go IDLE.
- Non-owner waitrequest stays high throughout; readdata of the non-owner holds its last value.
- No requester may deassert read/write while waitrequest is high (Avalon rule); the bench flags violations, the RTL does not check.

## Timing

- Reset values: state=IDLE, last_grant=B, all waitrequest=1, all readdatavalid=0, all readdata=0, ram_address=0, ram_byteenable=0, ram_chipselect=0, ram_write=0, ram_writedata=0.
- Reset asserted mid-transaction: FSM returns to IDLE next edge, pending access is dropped, no readdatavalid emitted.
- Write: request seen cycle 0 (IDLE) -> accept cycle 1 (ISSUE, waitrequest low) -> IDLE cycle 2. Throughput one write per 2 cycles.
- Read: request cycle 0 -> accept cycle 1 -> READ_WAIT cycle 2 -> readdatavalid+data cycle 3. One read per 4 cycles; latency from accept to readdatavalid is 2 cycles, fixed.
- reset_req high in ISSUE extends ISSUE by exactly the number of cycles reset_req is high.
- Address wraps naturally within ADDR_W; no range check.

## Test plan

- Reset then A write addr 2, data 0xDEADBEEF, be 0xF -> ram_write high one cycle with addr 2, a_waitrequest low in cycle 1; subsequent A read addr 2 -> a_readdatavalid in cycle 3 of that read with 0xDEADBEEF.
- A and B both request reads in the same cycle (addr 0 and 1) -> A accepted first, B accepted in the cycle A's RESP ends + 1; next simultaneous pair -> B first.
- Byte-lane write from B, data 0x11223344 be 0x3 over prior 0xDEADBEEF -> read back 0xDEAD3344.
- reset_req held high 3 cycles while in ISSUE -> ram_clken low 3 cycles, waitrequest stays high, accept occurs on the 4th cycle, data correct.
- reset asserted during READ_WAIT -> no readdatavalid, all outputs at reset values next cycle, next request served normally.
- A asserts read and write together at addr 3 -> write performed, no readdatavalid produced.
